// File: rtl/pipe_skid_buffer.sv
// Valid/ready pipeline stage with a one-entry skid register.
// in_ready, out_valid and out_data all come straight from flops.
module pipe_skid_buffer #(
    parameter int unsigned bitz = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [bitz-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [bitz-1:0] out_data,
    input  logic            out_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic            in_ready_q;
    logic            in_ready_d;
    logic [bitz-1:0] out_data_q;
    logic [bitz-1:0] out_data_d;
    logic [bitz-1:0] skid_q;
    logic [bitz-1:0] skid_d;
    logic            push_s;
    logic            pop_s;

    assign push_s = in_valid & in_ready_q;
    assign pop_s  = out_valid_q & out_ready;

    // Next-state and datapath selection; flush overrides every handshake.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        out_data_d = in_data;
                        state_d    = ST_BUSY;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (push_s && pop_s) begin
                        out_data_d = in_data;
                        state_d    = ST_BUSY;
                    end else if (push_s) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the consumer can move us.
                    if (out_ready) begin
                        out_data_d = skid_q;
                        state_d    = ST_BUSY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and output registers; in_ready stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= {bitz{1'b0}};
            skid_q      <= {bitz{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            skid_q      <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed vector table, reset corners,
// and a randomized phase checked against a word-count scoreboard.
module tb_pipe_skid_buffer;

    localparam int W = 8;

    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic         e_ir;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] sb_q[$];
    logic         cur_ready;
    vec_t         vecs[25];
    logic         r_fl;
    logic         r_iv;
    logic         r_ordy;
    logic [W-1:0] r_d;

    pipe_skid_buffer #(.bitz(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkd(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, clock, update the scoreboard, sample 1 time unit later.
    task automatic step(logic fl, logic iv, logic [W-1:0] d, logic ordy);
        logic         pre_ov;
        logic [W-1:0] pre_od;
        logic [W-1:0] exp_w;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        pre_ov    = out_valid;
        pre_od    = out_data;
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (pre_ov && ordy) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got word %02h expected no word", pre_od);
                end else begin
                    exp_w = sb_q.pop_front();
                    if (pre_od !== exp_w) begin
                        errors++;
                        $display("FAIL sb_order: got %02h expected %02h", pre_od, exp_w);
                    end
                end
            end
            if (iv && cur_ready) sb_q.push_back(d);
        end
        #1;
    endtask

    initial begin
        // fl iv d ordy | e_ov e_od e_ir
        vecs[0]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1}; // release edge: no accept
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 8'hA1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 1'b1}; // A3 refused on release
        vecs[15] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 8'h00, 1'b1}; // flush in FULL
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 8'hC1, 1'b1};
        vecs[22] = '{1'b1, 1'b1, 8'hC2, 1'b1, 1'b0, 8'h00, 1'b1}; // flush beats both handshakes
        vecs[23] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1};
        vecs[24] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        cur_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chkd("rst_out_data", out_data, 8'h00);
        chk1("rst_in_ready", in_ready, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk1($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk1($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            if (vecs[i].e_ov) chkd($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
            cur_ready = vecs[i].e_ir;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d words left expected 0", sb_q.size());
        end

        // Asynchronous reset between edges while BUSY.
        step(1'b0, 1'b1, 8'hD1, 1'b0);
        chk1("busy_out_valid", out_valid, 1'b1);
        chkd("busy_out_data", out_data, 8'hD1);
        #3;
        reset = 1'b0;
        #1;
        chk1("async_out_valid", out_valid, 1'b0);
        chk1("async_in_ready", in_ready, 1'b0);
        chkd("async_out_data", out_data, 8'h00);
        sb_q.delete();
        cur_ready = 1'b0;
        #2;
        reset = 1'b1;
        step(1'b0, 1'b1, 8'h66, 1'b1);
        chk1("rel_out_valid", out_valid, 1'b0);
        chk1("rel_in_ready", in_ready, 1'b1);

        // Random traffic: held-word count fixes both out_valid and in_ready.
        for (int n = 0; n < 300; n++) begin
            r_fl   = ($urandom_range(0, 15) == 0);
            r_iv   = 1'($urandom_range(0, 1));
            r_ordy = 1'($urandom_range(0, 1));
            r_d    = W'($urandom);
            cur_ready = (sb_q.size() < 2);
            chk1("rnd_in_ready", in_ready, cur_ready);
            chk1("rnd_out_valid", out_valid, sb_q.size() > 0);
            if (sb_q.size() > 0) chkd("rnd_out_data", out_data, sb_q[0]);
            step(r_fl, r_iv, r_d, r_ordy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_buffer.md
# pipe_skid_buffer

Registered valid/ready pipeline stage that accepts words from an upstream producer and presents them to a downstream consumer, with a one-entry skid register so both `in_ready` and `out_valid`/`out_data` come straight from flops. It sits between pipeline stages where the consuming stage can stall, such as a decode stage fed by fetch. It also sits anywhere a plain register stage must gain backpressure without a combinational ready path. A synchronous flush empties the stage for branch or exception recovery.

## Interface
- `bitz`, 32, data word width in bits (≥1)
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `flush`  input  1  synchronous; discards all held words
- `in_valid`  input  1  upstream word present on `in_data`
- `in_data`  input  bitz  upstream word
- `in_ready`  output  1  stage can accept a word this cycle (registered)
- `out_valid`  output  1  `out_data` holds a valid word (registered)
- `out_data`  output  bitz  downstream word (registered)
- `out_ready`  input  1  downstream accepts `out_data` this cycle

## Operation
- Transfer in: `in_valid & in_ready` sampled at a rising edge. Transfer out: `out_valid & out_ready` sampled at a rising edge.
- Storage: output register `out_data` and skid register `skid_data`, each `bitz` wide.
- States:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - BUSY: one word in the output register. `out_valid`=1, `in_ready`=1.
  - FULL: output and skid registers both occupied. `out_valid`=1, `in_ready`=0.
- EMPTY: on transfer in, load `out_data` and go to BUSY. Otherwise stay.
- BUSY:
  - In and out together: load `out_data` with `in_data`, stay in BUSY.
  - In only: write `skid_data`, go to FULL.
  - Out only: go to EMPTY.
  - Neither: stay.
- FULL:
  - `out_ready`: `out_data` takes `skid_data`, go to BUSY.
  - Otherwise hold.
  - `in_valid` is ignored because `in_ready`=0.
- Flush:
  - Next state is EMPTY, regardless of state or handshakes that cycle.
  - Any word offered or presented that cycle is dropped. Flush takes priority over all transfers.
  - Data registers need not clear on flush.
- Ordering: words leave in acceptance order. No drops or duplicates, except on flush.
- Hold rule: while `out_valid`=1 and `out_ready`=0, `out_data` does not change.
- `out_valid` does not fall without a transfer out or a flush.

## Timing
- Reset asserted (asynchronous, regardless of clock):
  - state EMPTY, `out_valid`=0, `out_data`=0, `skid_data`=0.
  - `in_ready`=0, held while `reset` is low.
- After `reset` deasserts, `in_ready` rises at the first rising edge. No transfer is accepted at that edge.
- Reset asserted mid-operation discards all held words immediately.
- Latency: a word accepted at edge N is on `out_data` with `out_valid`=1 after edge N, or after the edge where it leaves the skid register.
- Throughput: one word per cycle when `out_ready` stays high.
- `in_ready` depends only on registered state, so there is no combinational path from `out_ready` to `in_ready`.
- `out_ready` low for k cycles with `in_valid` held high gives:
  - exactly one extra word captured into skid;
  - `in_ready` low from the next edge until one edge after `out_ready` returns.
- Flush at edge N: after N, `out_valid`=0 and `in_ready`=1.

## Test plan
- Reset, `bitz`=8. Hold `reset` low 2 cycles, then release. Require:
  - `out_valid`=0, `out_data`=8'h00, `in_ready`=0 during reset;
  - `in_ready`=1 one edge after release.
- Streaming. Send 8'h11, 8'h22, 8'h33 on consecutive cycles with `out_ready`=1. Require:
  - `out_data` 11, 22, 33 on consecutive cycles, each one cycle after acceptance;
  - `in_ready` stays 1.
- Stall into skid. Send 8'hA1 then 8'hA2 with `out_ready`=0. Require:
  - `in_ready`=0 after A2 is accepted;
  - `out_data`=A1 held for 4 stalled cycles.
  - Then raise `out_ready` and require A1 then A2, then `out_valid`=0.
- Stall release with new input. In FULL holding A1/A2, raise `out_ready` and keep `in_valid` with 8'hA3. Require:
  - A3 is not accepted on the release edge;
  - A3 is accepted the next cycle;
  - output order is A1, A2, A3.
- Flush in FULL. With `in_valid`=1 and 8'hB0 offered, assert `flush` for one cycle. Require:
  - `out_valid`=0 and `in_ready`=1 next cycle;
  - A1, A2 and B0 are never output.
- Asynchronous reset mid-stream. Drop `reset` between clock edges while BUSY. Require `out_valid`=0 immediately, without waiting for an edge.
